// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the SPI flash bridge.
package spi_flash_pkg;

  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_ADDR     = 4'd2,
    ST_DUMMY    = 4'd3,
    ST_RD_FETCH = 4'd4,
    ST_RD_SHIFT = 4'd5,
    ST_WR_DATA  = 4'd6,
    ST_WR_BUS   = 4'd7,
    ST_STATUS   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    return {6'b0, wel, wip};
  endfunction

endpackage

// File: rtl/spi_flash_wb_bridge_shifter.sv
// SPI mode-0 slave front end: input synchronisers, sck edge strobes, bit
// counting and the RX/TX shift registers driving miso_o.
module spi_slave_shifter
  import spi_flash_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       ss_i,
  input  logic       mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic       ss_hi_o,
  output logic       ss_fall_o,
  output logic       shift_done_o,
  output logic       miso_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             fall_cnt_q, fall_cnt_d;
  logic [6:0]             rx_sr_q, rx_sr_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic                   miso_q, miso_d;

  logic       sck_s, ss_s, mosi_s, rise, fall;
  logic [7:0] tx_src;
  logic [2:0] fcnt_src;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  // A load coinciding with a fall must put the new MSB straight on miso.
  assign tx_src   = tx_load_i ? tx_byte_i : tx_sr_q;
  assign fcnt_src = tx_load_i ? 3'd0 : fall_cnt_q;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    fall_cnt_d = fall_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    if (ss_s) begin
      bit_cnt_d  = 3'd0;
      fall_cnt_d = 3'd0;
      rx_sr_d    = 7'd0;
      miso_d     = 1'b0;
    end else begin
      if (rise) begin
        rx_sr_d   = {rx_sr_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      tx_sr_d    = tx_src;
      fall_cnt_d = fcnt_src;
      if (fall) begin
        miso_d     = tx_en_i & tx_src[7];
        tx_sr_d    = {tx_src[6:0], 1'b0};
        fall_cnt_d = fcnt_src + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      fall_cnt_q  <= 3'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'd0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      bit_cnt_q   <= bit_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
    end
  end

  assign byte_done_o  = ~ss_s & rise & (bit_cnt_q == 3'd7);
  assign rx_byte_o    = {rx_sr_q, mosi_s};
  assign ss_hi_o      = ss_s;
  assign ss_fall_o    = ~ss_s & ss_prev_q;
  assign shift_done_o = ~ss_s & fall & (fcnt_src == 3'd7);
  assign miso_o       = miso_q;

endmodule

// File: rtl/spi_flash_wb_bridge.sv
// Serial-flash command emulator bridging an SPI mode-0 slave to a Wishbone byte
// memory. Optional FAST_READ (0x0B + dummy byte) enabled by SPI_FLASH_FAST_READ_EN.
//
// state       | meaning
// ST_IDLE     | ss high, waiting for ss falling
// ST_CMD      | receiving opcode byte
// ST_ADDR     | receiving ADDR_BYTES address bytes, MSB first
// ST_DUMMY    | fast read dummy byte, prefetch in flight
// ST_RD_FETCH | Wishbone read for next TX byte
// ST_RD_SHIFT | shifting read byte out on miso
// ST_WR_DATA  | receiving page-program data byte
// ST_WR_BUS   | Wishbone write of received byte
// ST_STATUS   | shifting status register out repeatedly
// ST_IGNORE   | unsupported/finished command, wait for ss high
module spi_flash_wb_bridge
  import spi_flash_pkg::*;
#(
  parameter  int ADDR_BYTES  = 3,
  parameter  int PAGE_BITS   = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = 8 * ADDR_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [7:0]        wb_dat_o,
  input  logic [7:0]        wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_BITS) - 64'd1);
  localparam logic [1:0]        LAST_ADDR = 2'(ADDR_BYTES - 1);

  state_e            state_q, state_d;
  logic              wel_q, wel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [7:0]        dat_q, dat_d;
`ifdef SPI_FLASH_FAST_READ_EN
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic              fetched_q, fetched_d;
`endif

  logic       byte_done, ss_hi, ss_fall, shift_done, tx_load, tx_en, bus_done;
  logic [7:0] rx_byte, tx_byte, rd_data;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sck_i        (sck_i),
    .ss_i         (ss_i),
    .mosi_i       (mosi_i),
    .tx_load_i    (tx_load),
    .tx_byte_i    (tx_byte),
    .tx_en_i      (tx_en),
    .byte_done_o  (byte_done),
    .rx_byte_o    (rx_byte),
    .ss_hi_o      (ss_hi),
    .ss_fall_o    (ss_fall),
    .shift_done_o (shift_done),
    .miso_o       (miso_o)
  );

  assign bus_done = cyc_q & (wb_ack_i | wb_err_i);
  assign rd_data  = wb_err_i ? 8'hFF : wb_dat_i;
  assign tx_en    = (state_q == ST_RD_FETCH) || (state_q == ST_RD_SHIFT) ||
                    (state_q == ST_STATUS);

  always_comb begin
    state_d    = state_q;
    wel_d      = wel_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    byte_cnt_d = byte_cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    dat_d      = dat_q;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
`ifdef SPI_FLASH_FAST_READ_EN
    rd_buf_d   = rd_buf_q;
    fetched_d  = fetched_q;
`endif

    // Bus cycles finish independently of the SPI side; writes always commit.
    if (bus_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      if (we_q) addr_d = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);
    end

    if (ss_hi) begin
      state_d = ST_IDLE;
      if (state_q == ST_WR_DATA || state_q == ST_WR_BUS) wel_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (ss_fall) state_d = ST_CMD;
        ST_CMD: if (byte_done) begin
          cmd_d      = rx_byte;
          byte_cnt_d = 2'd0;
          case (rx_byte)
            OP_WREN: begin wel_d = 1'b1; state_d = ST_IGNORE; end
            OP_WRDI: begin wel_d = 1'b0; state_d = ST_IGNORE; end
            OP_RDSR: begin
              state_d = ST_STATUS;
              tx_load = 1'b1;
              tx_byte = status_byte(wel_q, cyc_q);
            end
            OP_READ:      state_d = ST_ADDR;
            OP_PP:        state_d = wel_q ? ST_ADDR : ST_IGNORE;
`ifdef SPI_FLASH_FAST_READ_EN
            OP_FAST_READ: state_d = ST_ADDR;
`endif
            default:      state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR: if (byte_done) begin
          addr_d     = {addr_q[ADDR_W-9:0], rx_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_ADDR) begin
            if (cmd_q == OP_PP) begin
              state_d = ST_WR_DATA;
`ifdef SPI_FLASH_FAST_READ_EN
            end else if (cmd_q == OP_FAST_READ) begin
              state_d   = ST_DUMMY;
              cyc_d     = 1'b1;
              we_d      = 1'b0;
              fetched_d = 1'b0;
`endif
            end else begin
              state_d = ST_RD_FETCH;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
            end
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          if (bus_done && !we_q && !fetched_q) begin
            rd_buf_d  = rd_data;
            fetched_d = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
          end
          if (byte_done) begin
            if (fetched_q || (bus_done && !we_q)) begin
              tx_load = 1'b1;
              tx_byte = fetched_q ? rd_buf_q : rd_data;
              state_d = ST_RD_SHIFT;
            end else begin
              state_d = ST_RD_FETCH;
            end
          end
        end
`endif
        ST_RD_FETCH: if (bus_done) begin
          tx_load = 1'b1;
          tx_byte = rd_data;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RD_SHIFT;
        end
        ST_RD_SHIFT: if (shift_done) begin
          state_d = ST_RD_FETCH;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
        end
        ST_WR_DATA: if (byte_done) begin
          dat_d   = rx_byte;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          state_d = ST_WR_BUS;
        end
        ST_WR_BUS: if (bus_done) state_d = ST_WR_DATA;
        ST_STATUS: if (byte_done) begin
          tx_load = 1'b1;
          tx_byte = status_byte(wel_q, cyc_q);
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wel_q      <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= 8'h00;
      byte_cnt_q <= 2'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= 8'h00;
`ifdef SPI_FLASH_FAST_READ_EN
      rd_buf_q   <= 8'h00;
      fetched_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wel_q      <= wel_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      byte_cnt_q <= byte_cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
`ifdef SPI_FLASH_FAST_READ_EN
      rd_buf_q   <= rd_buf_d;
      fetched_q  <= fetched_d;
`endif
    end
  end

  assign wb_adr_o = addr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_sel_o = cyc_q;
  assign busy_o   = cyc_q;

endmodule
